glb_bank_sram_responder: RTL and testbench
==========================================

// Module: glb_bank_sram_responder
// PURPOSE
//  Bank-side responder for GLB packet traffic. Consumes wr_packet_t and rdrq_packet_t from the tile router.
//  Drives one single-port SRAM macro and returns rdrs_packet_t read responses in request order.
//  Sits between the per-tile packet switch and the bank SRAM wrapper; one instance per bank.
// PARAMETERS
//  BANK_DATA_WIDTH   64  SRAM word width in bits; wr_strb width is BANK_DATA_WIDTH/8
//  GLB_ADDR_WIDTH    22  global byte address width carried in packets
//  BANK_ADDR_WIDTH   17  bank-local byte address width (bits [BANK_ADDR_WIDTH-1:0] of packet addr)
//  SRAM_LATENCY      1   macro read latency in cycles (cen cycle -> sram_data_out valid), >=1
//  RDQ_DEPTH         2   pending-read queue depth, >=1
// PORTS
//  clk               in   1                    clock
//  reset             in   1                    synchronous, active-high reset
//  packet_wr_in      in   $bits(wr_packet_t)   write packet (wr_en qualifies)
//  packet_rdrq_in    in   $bits(rdrq_packet_t) read request packet (rd_en qualifies)
//  packet_rdrs_out   out  $bits(rdrs_packet_t) read response (rd_data_valid qualifies)
//  sram_cen          out  1                    SRAM access enable, active-high
//  sram_wen          out  1                    1 = write access, 0 = read access
//  sram_addr         out  BANK_ADDR_WIDTH-3    word address = addr[BANK_ADDR_WIDTH-1:3] (64b data)
//  sram_data_in      out  BANK_DATA_WIDTH      write data
//  sram_bit_wen      out  BANK_DATA_WIDTH      per-bit write enable, bit i = wr_strb[i/8]
//  sram_data_out     in   BANK_DATA_WIDTH      SRAM read data, valid SRAM_LATENCY cycles after read cen
//  rdq_overflow      out  1                    sticky: a read was dropped due to full queue
// BEHAVIOUR
//  - Reset: all outputs 0 (rd_data, rd_data_valid, sram_*, rdq_overflow); queue and pipeline flushed.
//  - SRAM outputs are combinational from the current-cycle arbitration; at most one access per cycle.
//  - Effective write: wr_en=1 and wr_strb!=0. wr_en=1 with wr_strb=0 is a no-op and does not occupy the port.
//  - Priority per cycle: effective write > queue head > new read.
//  - New read goes straight to SRAM only if there is no write and the queue is empty; otherwise it is enqueued.
//  - Queue head issues in any cycle without a write. Reads leave strictly in arrival order.
//  - Same-cycle queue pop and push are allowed; occupancy is unchanged.
//  - Queue full with a new read that cannot issue: the read is dropped, rdq_overflow<=1 (cleared only by reset).
//  - Response timing: read accessed at cycle t -> rd_data_valid=1 at cycle t+SRAM_LATENCY+1 (registered),
//    with rd_data = sram_data_out captured at t+SRAM_LATENCY.
//  - rd_data_valid is high for exactly one cycle per read. rd_data holds its last value while valid=0.
//  - Read and write to the same address in the same cycle: the write wins the port and the read issues later,
//    so the read returns the post-write data.
//  - Address bits above BANK_ADDR_WIDTH (bank select) are ignored.
//  - Low 3 bits of the address (byte offset) are ignored; the strobe selects bytes.
//  - Reset mid-operation: in-flight valid shift bits and queued reads are discarded; no response is produced for them.
//  - Pipeline: valid shift register of length SRAM_LATENCY+1. There is no backpressure; the consumer must accept every response.
// STRUCTURE
//  - Package global_buffer_param gains BANK_ADDR_WIDTH and BANK_BYTE_OFFSET (= $clog2(BANK_DATA_WIDTH/8)).
//  - Reuse wr_packet_t, rdrq_packet_t and rdrs_packet_t from global_buffer_pkg unchanged.
//  - Sub-module glb_bank_rdq: synchronous FIFO of bank-local word addresses (RDQ_DEPTH).
//    Ports: push, pop, din, dout, empty, full; same clk/reset.
//  - Top level holds the arbiter (combinational), the valid/data response pipeline and the overflow flag.
// TESTING
//  1. Write addr 0x10, strb 0xFF, data 0xDEAD_BEEF_0123_4567; read 0x10 two cycles later.
//     -> rd_data_valid exactly 2 cycles after rd_en, rd_data = written value.
//  2. Write 0x10 full 0xFFFF..FF, then strb 0x0F data 0.
//     -> sram_bit_wen = 0x0000_0000_FFFF_FFFF; readback = 0xFFFF_FFFF_0000_0000.
//  3. Write and read to 0x20 in the same cycle, prior content 0, write data 5.
//     -> read queued 1 cycle, valid at rd_en+3, rd_data = 5.
//  4. 4 back-to-back writes, reads on cycles 0,1 (RDQ_DEPTH=2) plus a 3rd read on cycle 2.
//     -> first two returned in order after the writes; 3rd dropped; rdq_overflow=1.
//  5. wr_en=1 with strb=0 concurrent with a read -> read issues immediately (no queueing), sram_wen=0.
//  6. Reset asserted one cycle after a read issue.
//     -> no rd_data_valid afterwards; all outputs 0; rdq_overflow cleared.

Source files
------------

// File: rtl/glb_bank_sram_responder_pkg.sv
// Shared GLB parameters and packet types used by the bank-side SRAM responder.
// Bank-local address split and strobe expansion helper live here too.
package global_buffer_param;
    localparam int BANK_DATA_WIDTH  = 64;
    localparam int GLB_ADDR_WIDTH   = 22;
    localparam int BANK_ADDR_WIDTH  = 17;
    localparam int BANK_STRB_WIDTH  = BANK_DATA_WIDTH / 8;
    localparam int BANK_BYTE_OFFSET = $clog2(BANK_DATA_WIDTH / 8);
    localparam int BANK_WORD_WIDTH  = BANK_ADDR_WIDTH - BANK_BYTE_OFFSET;
endpackage

package global_buffer_pkg;
    import global_buffer_param::*;

    typedef struct packed {
        logic                       wr_en;
        logic [BANK_STRB_WIDTH-1:0] wr_strb;
        logic [GLB_ADDR_WIDTH-1:0]  wr_addr;
        logic [BANK_DATA_WIDTH-1:0] wr_data;
    } wr_packet_t;

    typedef struct packed {
        logic                      rd_en;
        logic [GLB_ADDR_WIDTH-1:0] rd_addr;
    } rdrq_packet_t;

    typedef struct packed {
        logic [BANK_DATA_WIDTH-1:0] rd_data;
        logic                       rd_data_valid;
    } rdrs_packet_t;

    function automatic logic [BANK_DATA_WIDTH-1:0] strb_to_bit_wen(
        input logic [BANK_STRB_WIDTH-1:0] strb
    );
        logic [BANK_DATA_WIDTH-1:0] bw;
        bw = '0;
        for (int i = 0; i < BANK_STRB_WIDTH; i++) begin
            bw[i*8 +: 8] = {8{strb[i]}};
        end
        return bw;
    endfunction
endpackage

// File: rtl/glb_bank_sram_responder_rdq.sv
// Pending-read FIFO of bank-local word addresses.
// A pop frees a slot for a push in the same cycle.
module glb_bank_rdq #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage: written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; reset discards queued reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/glb_bank_sram_responder.sv
// Bank responder: arbitrates writes and reads onto one single-port SRAM
// and returns read data in request order through a fixed-latency pipe.
module glb_bank_sram_responder
    import global_buffer_param::*;
    import global_buffer_pkg::*;
#(
    parameter int SRAM_LATENCY = 1,
    parameter int RDQ_DEPTH    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  wr_packet_t                 packet_wr_in,
    input  rdrq_packet_t               packet_rdrq_in,
    output rdrs_packet_t               packet_rdrs_out,
    output logic                       sram_cen,
    output logic                       sram_wen,
    output logic [BANK_WORD_WIDTH-1:0] sram_addr,
    output logic [BANK_DATA_WIDTH-1:0] sram_data_in,
    output logic [BANK_DATA_WIDTH-1:0] sram_bit_wen,
    input  logic [BANK_DATA_WIDTH-1:0] sram_data_out,
    output logic                       rdq_overflow
);
    logic [BANK_WORD_WIDTH-1:0] wr_word;
    logic [BANK_WORD_WIDTH-1:0] rd_word;
    logic [BANK_WORD_WIDTH-1:0] q_dout;
    logic                       q_empty;
    logic                       q_full;
    logic                       q_push;
    logic                       q_pop;
    logic                       wr_eff;
    logic                       rd_new;
    logic                       head_go;
    logic                       direct_go;
    logic                       rd_issue;
    logic                       rd_drop;
    logic [SRAM_LATENCY:0]      vld_sr;
    logic [BANK_DATA_WIDTH-1:0] rd_data_q;
    logic                       unused_addr_bits;

    assign wr_word = packet_wr_in.wr_addr[BANK_ADDR_WIDTH-1:BANK_BYTE_OFFSET];
    assign rd_word = packet_rdrq_in.rd_addr[BANK_ADDR_WIDTH-1:BANK_BYTE_OFFSET];

    assign unused_addr_bits = ^{
        packet_wr_in.wr_addr[GLB_ADDR_WIDTH-1:BANK_ADDR_WIDTH],
        packet_wr_in.wr_addr[BANK_BYTE_OFFSET-1:0],
        packet_rdrq_in.rd_addr[GLB_ADDR_WIDTH-1:BANK_ADDR_WIDTH],
        packet_rdrq_in.rd_addr[BANK_BYTE_OFFSET-1:0]
    };

    assign wr_eff    = !reset && packet_wr_in.wr_en && (|packet_wr_in.wr_strb);
    assign rd_new    = !reset && packet_rdrq_in.rd_en;
    assign head_go   = !reset && !wr_eff && !q_empty;
    assign direct_go = !wr_eff && q_empty && rd_new;
    assign rd_issue  = head_go || direct_go;
    assign q_pop     = head_go;
    assign q_push    = rd_new && !direct_go && (!q_full || q_pop);
    assign rd_drop   = rd_new && !direct_go && q_full && !q_pop;

    glb_bank_rdq #(
        .DEPTH (RDQ_DEPTH),
        .WIDTH (BANK_WORD_WIDTH)
    ) u_rdq (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .din   (rd_word),
        .dout  (q_dout),
        .empty (q_empty),
        .full  (q_full)
    );

    // Port arbitration: write, then queue head, then a fresh read.
    always_comb begin
        sram_cen     = 1'b0;
        sram_wen     = 1'b0;
        sram_addr    = '0;
        sram_data_in = '0;
        sram_bit_wen = '0;
        unique case (1'b1)
            wr_eff: begin
                sram_cen     = 1'b1;
                sram_wen     = 1'b1;
                sram_addr    = wr_word;
                sram_data_in = packet_wr_in.wr_data;
                sram_bit_wen = strb_to_bit_wen(packet_wr_in.wr_strb);
            end
            head_go: begin
                sram_cen  = 1'b1;
                sram_addr = q_dout;
            end
            direct_go: begin
                sram_cen  = 1'b1;
                sram_addr = rd_word;
            end
            default: ;
        endcase
    end

    // Valid pipe tracks each issued read until its data is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[SRAM_LATENCY-1:0], rd_issue};
        end
    end

    // Capture macro output on the cycle it becomes valid; hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (vld_sr[SRAM_LATENCY-1]) begin
            rd_data_q <= sram_data_out;
        end
    end

    // Sticky flag for reads lost to a full queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdq_overflow <= 1'b0;
        end else if (rd_drop) begin
            rdq_overflow <= 1'b1;
        end
    end

    assign packet_rdrs_out.rd_data       = rd_data_q;
    assign packet_rdrs_out.rd_data_valid = vld_sr[SRAM_LATENCY];
endmodule

// File: tb/tb_glb_bank_sram_responder.sv
// Bench for glb_bank_sram_responder: directed scenarios plus random traffic
// checked against a transaction-level model of the bank.
module tb_glb_bank_sram_responder;
    import global_buffer_param::*;
    import global_buffer_pkg::*;

    localparam int LAT   = 1;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         reset;
    wr_packet_t   wr_pkt;
    rdrq_packet_t rq_pkt;
    rdrs_packet_t rs_pkt;
    logic         sram_cen;
    logic         sram_wen;
    logic [13:0]  sram_addr;
    logic [63:0]  sram_data_in;
    logic [63:0]  sram_bit_wen;
    logic [63:0]  sram_data_out;
    logic         rdq_overflow;

    always #5 clk = ~clk;

    glb_bank_sram_responder #(
        .SRAM_LATENCY (LAT),
        .RDQ_DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .packet_wr_in    (wr_pkt),
        .packet_rdrq_in  (rq_pkt),
        .packet_rdrs_out (rs_pkt),
        .sram_cen        (sram_cen),
        .sram_wen        (sram_wen),
        .sram_addr       (sram_addr),
        .sram_data_in    (sram_data_in),
        .sram_bit_wen    (sram_bit_wen),
        .sram_data_out   (sram_data_out),
        .rdq_overflow    (rdq_overflow)
    );

    // Behavioural SRAM macro with LAT-cycle read latency.
    logic [63:0] smem [int];
    logic [63:0] spipe [LAT];

    function automatic logic [63:0] smem_rd(input int a);
        return smem.exists(a) ? smem[a] : 64'd0;
    endfunction

    always @(posedge clk) begin
        if (sram_cen && sram_wen) begin
            smem[int'(sram_addr)] = (smem_rd(int'(sram_addr)) & ~sram_bit_wen)
                                  | (sram_data_in & sram_bit_wen);
        end
        for (int i = LAT - 1; i > 0; i--) spipe[i] <= spipe[i-1];
        if (sram_cen && !sram_wen) spipe[0] <= smem_rd(int'(sram_addr));
    end

    assign sram_data_out = spipe[LAT-1];

    // Reference model state
    typedef struct {
        int          due;
        logic [63:0] data;
    } resp_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          armed    = 0;
    bit          ovf_exp  = 0;
    logic [63:0] last_data = '0;
    int          pq[$];
    resp_t       rq[$];
    logic [63:0] rmem [int];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int word_of(input logic [21:0] a);
        return int'(a[16:3]);
    endfunction

    function automatic logic [63:0] mask_of(input logic [7:0] s);
        logic [63:0] m;
        m = 64'd0;
        for (int b = 0; b < 8; b++) if (s[b]) m |= 64'hFF << (8 * b);
        return m;
    endfunction

    function automatic logic [63:0] rmem_rd(input int w);
        return rmem.exists(w) ? rmem[w] : 64'd0;
    endfunction

    function automatic logic [21:0] rand_addr();
        logic [13:0] w;
        w = 14'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) w = w | 14'h3ff8;
        return {5'($urandom), w, 3'($urandom)};
    endfunction

    task automatic step(input bit rst, input bit we, input logic [7:0] strb,
                        input logic [21:0] waddr, input logic [63:0] wdata,
                        input bit re, input logic [21:0] raddr);
        bit issue, direct, wr_eff;
        int ia;
        @(negedge clk);
        reset          = rst;
        wr_pkt.wr_en   = we;
        wr_pkt.wr_strb = strb;
        wr_pkt.wr_addr = waddr;
        wr_pkt.wr_data = wdata;
        rq_pkt.rd_en   = re;
        rq_pkt.rd_addr = raddr;
        #1;
        if (armed) begin
            if (rq.size() > 0 && rq[0].due == cyc) begin
                check("rd_valid", 64'(rs_pkt.rd_data_valid), 64'd1);
                check("rd_data", rs_pkt.rd_data, rq[0].data);
                last_data = rq[0].data;
                void'(rq.pop_front());
            end else begin
                check("rd_valid_idle", 64'(rs_pkt.rd_data_valid), 64'd0);
                check("rd_data_hold", rs_pkt.rd_data, last_data);
            end
            check("rdq_overflow", 64'(rdq_overflow), 64'(ovf_exp));
        end
        if (rst) begin
            check("rst_cen", 64'(sram_cen), 64'd0);
            check("rst_wen", 64'(sram_wen), 64'd0);
            check("rst_addr", 64'(sram_addr), 64'd0);
            check("rst_din", sram_data_in, 64'd0);
            check("rst_bwen", sram_bit_wen, 64'd0);
            pq.delete();
            rq.delete();
            ovf_exp   = 0;
            last_data = '0;
            armed     = 1;
        end else begin
            wr_eff = we && (strb != 8'd0);
            issue  = 0;
            direct = 0;
            ia     = 0;
            if (wr_eff) begin
                check("wr_cen", 64'(sram_cen), 64'd1);
                check("wr_wen", 64'(sram_wen), 64'd1);
                check("wr_addr", 64'(sram_addr), 64'(word_of(waddr)));
                check("wr_din", sram_data_in, wdata);
                check("wr_bwen", sram_bit_wen, mask_of(strb));
            end else if (pq.size() > 0) begin
                ia    = pq.pop_front();
                issue = 1;
            end else if (re) begin
                ia     = word_of(raddr);
                issue  = 1;
                direct = 1;
            end
            if (issue) begin
                check("rd_cen", 64'(sram_cen), 64'd1);
                check("rd_wen", 64'(sram_wen), 64'd0);
                check("rd_addr", 64'(sram_addr), 64'(ia));
                rq.push_back('{due: cyc + LAT + 1, data: rmem_rd(ia)});
            end
            if (!wr_eff && !issue) check("idle_cen", 64'(sram_cen), 64'd0);
            if (re && !direct) begin
                if (pq.size() < DEPTH) pq.push_back(word_of(raddr));
                else ovf_exp = 1;
            end
            if (wr_eff) begin
                rmem[word_of(waddr)] = (rmem_rd(word_of(waddr)) & ~mask_of(strb))
                                     | (wdata & mask_of(strb));
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, '0, '0, 0, '0);
    endtask

    initial begin
        reset  = 1'b1;
        wr_pkt = '0;
        rq_pkt = '0;
        step(1, 0, 8'h00, '0, '0, 0, '0);
        step(1, 0, 8'h00, '0, '0, 0, '0);
        idle(2);

        // write then read back two cycles later
        step(0, 1, 8'hFF, 22'h10, 64'hDEAD_BEEF_0123_4567, 0, '0);
        idle(1);
        step(0, 0, 8'h00, '0, '0, 1, 22'h10);
        idle(3);

        // partial strobe over full-ones word
        step(0, 1, 8'hFF, 22'h10, 64'hFFFF_FFFF_FFFF_FFFF, 0, '0);
        step(0, 1, 8'h0F, 22'h10, 64'h0, 0, '0);
        step(0, 0, 8'h00, '0, '0, 1, 22'h10);
        idle(3);

        // same-cycle write and read to one address
        step(0, 1, 8'hFF, 22'h20, 64'h0, 0, '0);
        idle(1);
        step(0, 1, 8'hFF, 22'h20, 64'h5, 1, 22'h20);
        idle(4);

        // write burst with queued reads and one overflow
        step(0, 1, 8'hFF, 22'h40, 64'h1111, 1, 22'h40);
        step(0, 1, 8'hFF, 22'h48, 64'h2222, 1, 22'h48);
        step(0, 1, 8'hFF, 22'h50, 64'h3333, 1, 22'h50);
        step(0, 1, 8'hFF, 22'h58, 64'h4444, 0, '0);
        idle(6);

        // zero-strobe write does not block a read
        step(0, 1, 8'h00, 22'h40, 64'hBAD, 1, 22'h48);
        idle(3);

        // reset right after a read issue
        step(0, 0, 8'h00, '0, '0, 1, 22'h10);
        step(1, 0, 8'h00, '0, '0, 0, '0);
        idle(4);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            bit          r_rst, r_we, r_re;
            logic [7:0]  r_strb;
            r_rst  = ($urandom_range(0, 149) == 0);
            r_we   = ($urandom_range(0, 2) == 0);
            r_re   = ($urandom_range(0, 1) == 0);
            r_strb = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            step(r_rst, r_we, r_strb, rand_addr(),
                 {$urandom, $urandom}, r_re, rand_addr());
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
